// File: rtl/image_proc_pkg.sv
// image_proc_pkg: color codes, shape codes and frame FSM states
// shared by the shape/color classifier and its row width tracker.
package image_proc_pkg;

    typedef enum logic [1:0] {
        COLOR_NONE = 2'b00,
        COLOR_RED  = 2'b01,
        COLOR_BLUE = 2'b10
    } color_e;

    typedef enum logic [1:0] {
        SHAPE_NONE     = 2'b00,
        SHAPE_DIAMOND  = 2'b01,
        SHAPE_SQUARE   = 2'b10,
        SHAPE_TRIANGLE = 2'b11
    } shape_e;

    typedef enum logic [1:0] {
        PRIME  = 2'b00,
        ACCUM  = 2'b01,
        DECIDE = 2'b10
    } state_e;

    // RGB332: red channel top two bits dominates blue and green.
    function automatic logic px_is_red(input logic [7:0] px);
        return (px[7:6] > px[1:0]) && (px[7:6] > px[4:3]);
    endfunction

    // RGB332: blue channel dominates red and green; ties are neither.
    function automatic logic px_is_blue(input logic [7:0] px);
        return (px[1:0] > px[7:6]) && (px[1:0] > px[4:3]);
    endfunction

    function automatic logic [8:0] abs_diff9(
        input logic [8:0] a,
        input logic [8:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/row_width_tracker.sv
// row_width_tracker: counts colored pixels per row and keeps the
// widest qualifying row of every horizontal band.
module row_width_tracker
    import image_proc_pkg::*;
#(
    parameter int SCREEN_WIDTH   = 176,
    parameter int SCREEN_HEIGHT  = 144,
    parameter int NUM_BANDS      = 3,
    parameter int MIN_ROW_PIXELS = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clear,
    input  logic       pix_valid,
    input  logic       pix_colored,
    input  logic       frame_edge,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [7:0] w0,
    output logic [7:0] wm,
    output logic [7:0] wl
);

    localparam int BAND_H = SCREEN_HEIGHT / NUM_BANDS;
    localparam int BW     = $clog2(NUM_BANDS);

    logic [7:0]    row_width;
    logic [7:0]    row_base;
    logic [7:0]    row_sum;
    logic [7:0]    band_max [NUM_BANDS];
    logic [BW-1:0] band_idx;
    logic          row_end;

    // Row width including the current pixel; column 0 starts a new row.
    always_comb begin
        row_base = (pix_x == 10'd0) ? 8'd0 : row_width;
        row_sum  = row_base;
        if (pix_valid && pix_colored && row_base != 8'hFF)
            row_sum = row_base + 8'd1;
    end

    assign band_idx = BW'(pix_y / 10'(BAND_H));

    // A frame edge in the same cycle drops the row being closed.
    assign row_end = pix_valid && !frame_edge &&
                     (pix_x == 10'(SCREEN_WIDTH - 1));

    // Accumulate row width and capture the per-band maximum at row end.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            row_width <= '0;
            for (int i = 0; i < NUM_BANDS; i++)
                band_max[i] <= '0;
        end else if (row_end) begin
            row_width <= '0;
            if (row_sum >= 8'(MIN_ROW_PIXELS) &&
                row_sum > band_max[band_idx])
                band_max[band_idx] <= row_sum;
        end else begin
            row_width <= row_sum;
        end
    end

    assign w0 = band_max[0];
    assign wm = band_max[NUM_BANDS/2];
    assign wl = band_max[NUM_BANDS-1];

endmodule

// File: rtl/shape_color_classifier.sv
// shape_color_classifier: per-frame red/blue count and band-width
// shape decision. IMAGE_PROC_CONFIRM_EN adds multi-frame confirmation.
module shape_color_classifier
    import image_proc_pkg::*;
#(
    parameter int SCREEN_WIDTH   = 176,
    parameter int SCREEN_HEIGHT  = 144,
    parameter int NUM_BANDS      = 3,
    parameter int COLOR_THRESH   = 23000,
    parameter int MIN_ROW_PIXELS = 8,
    parameter int TRI_DELTA      = 7,
    parameter int DIA_DELTA      = 15,
    parameter int SQ_TOL         = 5
`ifdef IMAGE_PROC_CONFIRM_EN
    ,
    parameter int CONFIRM_FRAMES = 3
`endif
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [1:0] RESULT,
    output logic [1:0] SHAPE,
    output logic       FRAME_DONE
);

    localparam logic [15:0] THRESH16 = 16'(COLOR_THRESH);
    localparam logic [8:0]  TRI9     = 9'(TRI_DELTA);
    localparam logic [8:0]  DIA9     = 9'(DIA_DELTA);
    localparam logic [8:0]  SQ9      = 9'(SQ_TOL);

    state_e      state;
    state_e      state_next;
    logic        accum_en;
    logic        decide;
    logic        vsync_prev;
    logic        frame_edge;
    logic        in_area;
    logic        pix_valid;
    logic        pix_red;
    logic        pix_blue;
    logic [15:0] red_count;
    logic [15:0] blue_count;
    logic [7:0]  w0;
    logic [7:0]  wm;
    logic [7:0]  wl;
    logic [8:0]  w0_9;
    logic [8:0]  wm_9;
    logic [8:0]  wl_9;
    color_e      color_dec;
    shape_e      shape_dec;

    // Previous vsync level for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) vsync_prev <= 1'b0;
        else       vsync_prev <= VGA_VSYNC_NEG;
    end

    assign frame_edge = vsync_prev && !VGA_VSYNC_NEG;

    // Frame state register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= PRIME;
        else       state <= state_next;
    end

    // Frame edges advance PRIME and ACCUM; DECIDE lasts one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            PRIME:   if (frame_edge) state_next = ACCUM;
            ACCUM:   if (frame_edge) state_next = DECIDE;
            DECIDE:  state_next = ACCUM;
            default: state_next = PRIME;
        endcase
    end

    // State decode: pixel counting enable and decision cycle.
    always_comb begin
        accum_en = 1'b0;
        decide   = 1'b0;
        unique case (state)
            ACCUM:   accum_en = 1'b1;
            DECIDE:  decide   = 1'b1;
            default: ;
        endcase
    end

    assign in_area   = (VGA_PIXEL_X < 10'(SCREEN_WIDTH)) &&
                       (VGA_PIXEL_Y < 10'(SCREEN_HEIGHT));
    assign pix_valid = accum_en && in_area;
    assign pix_red   = px_is_red(PIXEL_IN);
    assign pix_blue  = px_is_blue(PIXEL_IN);

    // Saturating red/blue pixel counters, cleared by each decision.
    always_ff @(posedge CLK) begin
        if (RESET || decide) begin
            red_count  <= '0;
            blue_count <= '0;
        end else begin
            if (pix_valid && pix_red && red_count != 16'hFFFF)
                red_count <= red_count + 16'd1;
            if (pix_valid && pix_blue && blue_count != 16'hFFFF)
                blue_count <= blue_count + 16'd1;
        end
    end

    row_width_tracker #(
        .SCREEN_WIDTH   (SCREEN_WIDTH),
        .SCREEN_HEIGHT  (SCREEN_HEIGHT),
        .NUM_BANDS      (NUM_BANDS),
        .MIN_ROW_PIXELS (MIN_ROW_PIXELS)
    ) u_rows (
        .CLK         (CLK),
        .RESET       (RESET),
        .clear       (decide),
        .pix_valid   (pix_valid),
        .pix_colored (pix_red || pix_blue),
        .frame_edge  (frame_edge),
        .pix_x       (VGA_PIXEL_X),
        .pix_y       (VGA_PIXEL_Y),
        .w0          (w0),
        .wm          (wm),
        .wl          (wl)
    );

    assign w0_9 = {1'b0, w0};
    assign wm_9 = {1'b0, wm};
    assign wl_9 = {1'b0, wl};

    // Dominant color above threshold; blue takes priority.
    always_comb begin
        color_dec = COLOR_NONE;
        if (blue_count > red_count && blue_count > THRESH16)
            color_dec = COLOR_BLUE;
        else if (red_count > blue_count && red_count > THRESH16)
            color_dec = COLOR_RED;
    end

    // Shape from band widths, first match wins; no color means no shape.
    always_comb begin
        shape_dec = SHAPE_NONE;
        if (wl_9 > w0_9 + TRI9)
            shape_dec = SHAPE_TRIANGLE;
        else if (wm_9 > w0_9 + DIA9 && wm_9 > wl_9 + DIA9)
            shape_dec = SHAPE_DIAMOND;
        else if (abs_diff9(w0_9, wl_9) <= SQ9 &&
                 abs_diff9(wm_9, w0_9) <= SQ9 &&
                 w0_9 != 9'd0)
            shape_dec = SHAPE_SQUARE;
        if (color_dec == COLOR_NONE)
            shape_dec = SHAPE_NONE;
    end

`ifdef IMAGE_PROC_CONFIRM_EN
    localparam logic [2:0] CONFIRM_N = 3'(CONFIRM_FRAMES);

    logic [3:0] cand;
    logic [3:0] prev_cand;
    logic [2:0] match_cnt;
    logic [2:0] match_next;

    assign cand = {color_dec, shape_dec};

    // Run length of identical consecutive candidates, saturating.
    always_comb begin
        match_next = 3'd1;
        if (cand == prev_cand)
            match_next = (match_cnt == 3'd7) ? 3'd7 : match_cnt + 3'd1;
    end

    // Publish a candidate only after enough identical frames.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_cand <= '0;
            match_cnt <= '0;
            RESULT    <= COLOR_NONE;
            SHAPE     <= SHAPE_NONE;
        end else if (decide) begin
            prev_cand <= cand;
            match_cnt <= match_next;
            if (match_next >= CONFIRM_N) begin
                RESULT <= color_dec;
                SHAPE  <= shape_dec;
            end
        end
    end
`else
    // Publish every frame decision directly.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT <= COLOR_NONE;
            SHAPE  <= SHAPE_NONE;
        end else if (decide) begin
            RESULT <= color_dec;
            SHAPE  <= shape_dec;
        end
    end
`endif

    // One-cycle strobe following the decision cycle.
    always_ff @(posedge CLK) begin
        if (RESET) FRAME_DONE <= 1'b0;
        else       FRAME_DONE <= decide;
    end

endmodule

// File: doc/shape_color_classifier.md
# shape_color_classifier

Frame-level color and shape classifier on the camera pixel stream, next to the VGA pixel-address generator. Counts red/blue pixels per frame in RGB332, tracks the widest colored row in each of NUM_BANDS horizontal bands, and classifies the treasure as triangle, diamond or square from band widths. Adds a frame state machine, active-area gating, saturation, a frame-done strobe and optional multi-frame confirmation.

## Interface
- SCREEN_WIDTH, 176: active pixels per row.
- SCREEN_HEIGHT, 144: active rows per frame.
- NUM_BANDS, 3: horizontal bands, 3..4; band height is SCREEN_HEIGHT/NUM_BANDS, integer.
- COLOR_THRESH, 23000: minimum dominant-color pixel count for a color decision.
- MIN_ROW_PIXELS, 8: rows with fewer colored pixels are ignored for width tracking.
- TRI_DELTA, 7; DIA_DELTA, 15; SQ_TOL, 5: shape margins, in pixels.
- CONFIRM_FRAMES, 3: identical consecutive decisions required; only used under IMAGE_PROC_CONFIRM_EN.
- CLK  in  1  pixel clock; the only clock.
- RESET  in  1  synchronous, active-high.
- PIXEL_IN  in  8  RGB332, R[7:5], G[4:2], B[1:0].
- VGA_PIXEL_X  in  10  column of PIXEL_IN.
- VGA_PIXEL_Y  in  10  row of PIXEL_IN.
- VGA_VSYNC_NEG  in  1  vsync; falling edge marks frame end.
- RESULT  out  2  00 none, 01 red, 10 blue.
- SHAPE  out  2  00 none, 01 diamond, 10 square, 11 triangle.
- FRAME_DONE  out  1  one-cycle strobe when a frame decision is taken.

## Operation
- States: PRIME, ACCUM, DECIDE. Reset enters PRIME. PRIME goes to ACCUM on the first vsync falling edge, with no output update. The partial frame after reset is discarded. ACCUM goes to DECIDE on a vsync falling edge. DECIDE goes to ACCUM after one cycle.
- Falling edge: VGA_VSYNC_NEG low while the registered previous value is high. The previous value resets to 0.
- A pixel is counted only in ACCUM with X < SCREEN_WIDTH and Y < SCREEN_HEIGHT.
- Red when PIXEL_IN[7:6] > PIXEL_IN[1:0] and PIXEL_IN[7:6] > PIXEL_IN[4:3].
- Blue when PIXEL_IN[1:0] > PIXEL_IN[7:6] and PIXEL_IN[1:0] > PIXEL_IN[4:3]. Ties count as neither.
- REDCOUNT and BLUECOUNT are 16-bit and saturate at 0xFFFF.
- Row width is an 8-bit count of colored pixels in the current row, saturating.
- Row end: an in-area pixel with X == SCREEN_WIDTH-1.
  - If the row width is at least MIN_ROW_PIXELS, the band max for band Y/(SCREEN_HEIGHT/NUM_BANDS) becomes max(band max, row width).
  - The row width then clears.
  - The row width also clears when X == 0.
- Color decision in DECIDE:
  - Blue (10) when BLUECOUNT > REDCOUNT and BLUECOUNT > COLOR_THRESH.
  - Otherwise red (01) when REDCOUNT > BLUECOUNT and REDCOUNT > COLOR_THRESH.
  - Otherwise 00.
- Shape, with band maxima W0 (first band), Wm (band NUM_BANDS/2) and Wl (last band). Comparisons are unsigned and widened to 9 bits, so nothing wraps. First match wins:
  - Triangle 11 when Wl > W0 + TRI_DELTA.
  - Diamond 01 when Wm > W0 + DIA_DELTA and Wm > Wl + DIA_DELTA.
  - Square 10 when |W0 − Wl| ≤ SQ_TOL and |Wm − W0| ≤ SQ_TOL and W0 ≠ 0.
  - Otherwise 00.
- SHAPE is forced to 00 whenever the color decision is 00.
- DECIDE clears all counts, row width and band maxima, and pulses FRAME_DONE.

## Timing
- Reset values: RESULT 00, SHAPE 00, FRAME_DONE 0, all counters 0, state PRIME.
- If the edge is sampled in cycle t, DECIDE is cycle t+1. RESULT, SHAPE and FRAME_DONE are visible from t+2. FRAME_DONE is high for exactly cycle t+2.
- Pixels arriving in cycle t+1 are not counted. Pixels from cycle t+2 count toward the next frame.
- A partial row at frame end does not update any band max.
- A row end and a frame edge in the same cycle: the frame edge wins, and that row is dropped.
- RESET in any state overrides everything else in that cycle.
- Outputs hold between decisions.

## Configuration
- IMAGE_PROC_CONFIRM_EN defined:
  - Each decision is a candidate {color, shape}. A 3-bit match counter increments (saturating) while each new candidate equals the previous one, and restarts at 1 when it changes.
  - RESULT and SHAPE update only once the counter reaches CONFIRM_FRAMES.
  - FRAME_DONE still pulses every frame.
  - Reset clears the counter and the previous candidate.
- IMAGE_PROC_CONFIRM_EN undefined: every decision updates RESULT and SHAPE immediately, and no confirm logic is built.

## Structure
- Package image_proc_pkg holds the color codes, shape codes and the state enum (PRIME/ACCUM/DECIDE).
- One sub-module, row_width_tracker: row width counting, band indexing and band maxima. It exports W0, Wm and Wl.
- Color counting, the FSM and the decision logic live in the top level.

## Test plan
- Reset high for 3 cycles mid-frame, then two frames of solid blue (0x03) → no update at the first edge; after the second, RESULT=10 and FRAME_DONE is one cycle at t+2.
- Full frame of red (0xE0): 176×144 = 25344 pixels → RESULT=01, SHAPE=10 (all band widths 176).
- Red triangle with band maxima W0=20, Wm=60, Wl=100 → SHAPE=11. Blue diamond with 20/90/20 → SHAPE=01, RESULT=10.
- 22000 red pixels only → RESULT=00, SHAPE=00. Gray (0x6D, all ties) frame → REDCOUNT and BLUECOUNT stay 0.
- Pixels with X ≥ 176 or Y ≥ 144 are not counted.
- Under IMAGE_PROC_CONFIRM_EN, frame sequence red, red, blue, red, red, red → RESULT changes only after the 6th frame.
